// File: rtl/data_lsu_pkg.sv
// rtl/data_lsu_pkg.sv - shared type codes, FSM states and byte-mask helper for the load/store unit
package data_lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4
    } lsu_state_e;

    // Unaligned byte mask for an access size; the reserved code behaves as a word.
    function automatic logic [3:0] lsu_type_mask(input logic [1:0] typ);
        case (typ)
            LSU_BYTE: return 4'b0001;
            LSU_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_lsu_align.sv
// rtl/data_lsu_align.sv - combinational lane steering for stores and load extract/extend
module data_lsu_align
    import data_lsu_pkg::*;
(
    input  logic [1:0]  i_st_type,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_be1,
    output logic [3:0]  o_be2,
    output logic [31:0] o_wdata1,
    output logic [31:0] o_wdata2,
    output logic        o_split,
    input  logic [1:0]  i_ld_type,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_sext,
    input  logic [31:0] i_ld_lo,
    input  logic [23:0] i_ld_hi,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_be64;
    logic [63:0] w_wd64;
    logic [31:0] w_ld_word;

    // Shift the access mask and store data across a 64-bit window spanning two words.
    always_comb begin
        w_be64   = {4'b0000, lsu_type_mask(i_st_type)} << i_st_off;
        w_wd64   = {32'h0000_0000, i_st_wdata} << {i_st_off, 3'b000};
        o_be1    = w_be64[3:0];
        o_be2    = w_be64[7:4];
        o_wdata1 = w_wd64[31:0];
        o_wdata2 = w_wd64[63:32];
        o_split  = |w_be64[7:4];
    end

    // Right-justify the two-word read window by the byte offset; the top byte of the
    // second word can never land inside a 4-byte result, so it is not brought in.
    always_comb begin
        case (i_ld_off)
            2'd0:    w_ld_word = i_ld_lo;
            2'd1:    w_ld_word = {i_ld_hi[7:0],  i_ld_lo[31:8]};
            2'd2:    w_ld_word = {i_ld_hi[15:0], i_ld_lo[31:16]};
            default: w_ld_word = {i_ld_hi[23:0], i_ld_lo[31:24]};
        endcase
        case (i_ld_type)
            LSU_BYTE: o_ld_data = {{24{i_ld_sext & w_ld_word[7]}},  w_ld_word[7:0]};
            LSU_HALF: o_ld_data = {{16{i_ld_sext & w_ld_word[15]}}, w_ld_word[15:0]};
            default:  o_ld_data = w_ld_word;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// rtl/data_lsu.sv - load/store unit driving the req/gnt/rvalid data bus, with two-beat misaligned split
module data_lsu
    import data_lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_type;
    logic [1:0]  r_off;
    logic        r_sext;
    logic        r_split;
    logic [3:0]  r_be2;
    logic [31:0] r_wdata2;
    logic [29:0] r_word_addr;
    logic [31:0] r_rdata1;

    logic        w_accept;
    logic        w_err;
    logic        w_issue2;
    logic        w_complete;
    logic [3:0]  w_be1;
    logic [3:0]  w_be2;
    logic [31:0] w_wdata1;
    logic [31:0] w_wdata2;
    logic        w_split;
    logic [31:0] w_ld_lo;
    logic [23:0] w_ld_hi;
    logic [31:0] w_ld_data;

    assign lsu_ready_o = (r_state == ST_IDLE);

    // On the last beat of a split load the first word comes from the capture register.
    assign w_ld_lo = (r_state == ST_WAIT2) ? r_rdata1 : data_rdata_i;
    assign w_ld_hi = (r_state == ST_WAIT2) ? data_rdata_i[23:0] : 24'h00_0000;

    data_lsu_align u_align (
        .i_st_type  (lsu_type_i),
        .i_st_off   (lsu_addr_i[1:0]),
        .i_st_wdata (lsu_wdata_i),
        .o_be1      (w_be1),
        .o_be2      (w_be2),
        .o_wdata1   (w_wdata1),
        .o_wdata2   (w_wdata2),
        .o_split    (w_split),
        .i_ld_type  (r_type),
        .i_ld_off   (r_off),
        .i_ld_sext  (r_sext),
        .i_ld_lo    (w_ld_lo),
        .i_ld_hi    (w_ld_hi),
        .o_ld_data  (w_ld_data)
    );

    // Next-state and per-cycle strobes for accept, error, second-beat issue and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        w_issue2    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    if (w_split && !ALLOW_MISALIGNED) begin
                        w_err = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_REQ1;
                    end
                end
            end
            ST_REQ1: begin
                if (data_gnt_i) w_state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (data_rvalid_i) begin
                    if (r_split) begin
                        w_issue2    = 1'b1;
                        w_state_nxt = ST_REQ2;
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_REQ2: begin
                if (data_gnt_i) w_state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (data_rvalid_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Capture the request on accept and the first read word when a split load continues.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we        <= 1'b0;
            r_type      <= 2'b00;
            r_off       <= 2'b00;
            r_sext      <= 1'b0;
            r_split     <= 1'b0;
            r_be2       <= 4'h0;
            r_wdata2    <= 32'h0000_0000;
            r_word_addr <= 30'h0000_0000;
            r_rdata1    <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_we        <= lsu_we_i;
                r_type      <= lsu_type_i;
                r_off       <= lsu_addr_i[1:0];
                r_sext      <= lsu_sext_i;
                r_split     <= w_split;
                r_be2       <= w_be2;
                r_wdata2    <= w_wdata2;
                r_word_addr <= lsu_addr_i[31:2];
            end
            if (w_issue2) r_rdata1 <= data_rdata_i;
        end
    end

    // Registered bus outputs; address/enables/data only change when a new beat is loaded,
    // so they stay stable for the whole time req waits for grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'h0;
            data_addr_o  <= 32'h0000_0000;
            data_wdata_o <= 32'h0000_0000;
        end else begin
            data_req_o <= (w_state_nxt == ST_REQ1) || (w_state_nxt == ST_REQ2);
            if (w_accept) begin
                data_we_o    <= lsu_we_i;
                data_be_o    <= w_be1;
                data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                data_wdata_o <= w_wdata1;
            end else if (w_issue2) begin
                data_be_o    <= r_be2;
                data_addr_o  <= {r_word_addr + 30'd1, 2'b00};
                data_wdata_o <= r_wdata2;
            end
        end
    end

    // Pipeline-side completion and error pulses; stores return zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lsu_rvalid_o <= 1'b0;
            lsu_err_o    <= 1'b0;
            lsu_rdata_o  <= 32'h0000_0000;
        end else begin
            lsu_rvalid_o <= w_complete;
            lsu_err_o    <= w_err;
            lsu_rdata_o  <= (w_complete && !r_we) ? w_ld_data : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_lsu.sv
// tb/tb_data_lsu.sv - self-checking bench for data_lsu
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sext = 1'b0;
    logic [1:0]  lsu_type = 2'b00;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_ready, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt = 1'b0, data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;

    logic        m_req = 1'b0, m_we = 1'b0, m_sext = 1'b0;
    logic [1:0]  m_type = 2'b00;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_ready, m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic        m_dreq, m_dwe;
    logic [3:0]  m_dbe;
    logic [31:0] m_daddr, m_dwdata;
    logic        m_gnt = 1'b0, m_drvalid = 1'b0;
    logic [31:0] m_drdata = '0;

    data_lsu #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type), .lsu_sext_i(lsu_sext),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_ready_o(lsu_ready), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
        .data_addr_o(data_addr), .data_wdata_o(data_wdata),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
    );

    data_lsu #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(m_req), .lsu_we_i(m_we), .lsu_type_i(m_type), .lsu_sext_i(m_sext),
        .lsu_addr_i(m_addr), .lsu_wdata_i(m_wdata),
        .lsu_ready_o(m_ready), .lsu_rvalid_o(m_rvalid), .lsu_rdata_o(m_rdata), .lsu_err_o(m_err),
        .data_req_o(m_dreq), .data_we_o(m_dwe), .data_be_o(m_dbe),
        .data_addr_o(m_daddr), .data_wdata_o(m_dwdata),
        .data_gnt_i(m_gnt), .data_rvalid_i(m_drvalid), .data_rdata_i(m_drdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd1;
        logic [31:0] rd2;
        int          gd;
        int          rv;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt[14];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse pops the oldest expected load result.
    always @(negedge clk) begin
        if (rst_n && lsu_rvalid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("sb_rdata", lsu_rdata, exp_q.pop_front());
            end
        end
        if (rst_n && lsu_err) check("main_err", 32'd1, 32'd0);
    end

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          beats;
        int          w;
        logic [31:0] base;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        beats = (v.be2 != 4'h0) ? 2 : 1;
        base  = {v.addr[31:2], 2'b00};
        @(negedge clk);
        check("ready_idle", lsu_ready, 1);
        lsu_req = 1'b1; lsu_we = v.we; lsu_type = v.typ; lsu_sext = v.sext;
        lsu_addr = v.addr; lsu_wdata = v.wdata;
        exp_q.push_back(v.we ? 32'h0 : v.exp);
        @(negedge clk);
        lsu_req = 1'b0; lsu_wdata = $urandom; lsu_addr = $urandom;
        cyc = 1;
        check("ready_busy", lsu_ready, 0);
        for (int b = 0; b < beats; b++) begin
            ea = (b == 0) ? base : base + 32'd4;
            eb = (b == 0) ? v.be1 : v.be2;
            ew = (b == 0) ? v.wd1 : v.wd2;
            w = 0;
            while (!data_req && w < 20) begin @(negedge clk); w++; cyc++; end
            check("req_seen", data_req, 1);
            check("addr", data_addr, ea);
            check("be", data_be, eb);
            check("wdata", data_wdata, ew);
            check("we", data_we, v.we);
            for (int g = 0; g < v.gd; g++) begin
                @(negedge clk); cyc++;
                check("stall_req", data_req, 1);
                check("stall_addr", data_addr, ea);
                check("stall_be", data_be, eb);
                check("stall_wdata", data_wdata, ew);
                check("stall_ready", lsu_ready, 0);
            end
            data_gnt = 1'b1;
            @(negedge clk); cyc++;
            data_gnt = 1'b0;
            check("req_drop", data_req, 0);
            for (int r = 0; r < v.rv; r++) begin
                @(negedge clk); cyc++;
                check("wait_ready", lsu_ready, 0);
            end
            data_rvalid = 1'b1;
            data_rdata  = (b == 0) ? v.rd1 : v.rd2;
            @(negedge clk); cyc++;
            data_rvalid = 1'b0;
            data_rdata  = $urandom;
        end
        check("rvalid_pulse", lsu_rvalid, 1);
        check("ready_on_done", lsu_ready, 1);
        if (v.gd == 0 && v.rv == 0) check("latency", cyc, (beats == 1) ? 3 : 5);
        @(negedge clk);
        check("pulse_len", lsu_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //         we typ    sx addr           wdata          rd1            rd2           gd rv be1   wd1           be2   wd2           exp
        vt[0]  = '{0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 32'h0,        4'h0, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'h80112233, 32'h0,        0, 0, 4'h8, 32'h0,        4'h0, 32'h0,        32'hFFFFFF80};
        vt[2]  = '{0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h80112233, 32'h0,        0, 0, 4'h8, 32'h0,        4'h0, 32'h0,        32'h00000080};
        vt[3]  = '{1, 2'b10, 0, 32'h0000_0102, 32'hAABBCCDD,  32'h12345678, 32'h9ABCDEF0, 0, 0, 4'hC, 32'hCCDD0000, 4'h3, 32'h0000AABB, 32'h0};
        vt[4]  = '{0, 2'b01, 0, 32'h0000_0103, 32'h0,         32'h11000000, 32'h00000022, 0, 0, 4'h8, 32'h0,        4'h1, 32'h0,        32'h00002211};
        vt[5]  = '{0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'h80010000, 32'h0,        0, 0, 4'hC, 32'h0,        4'h0, 32'h0,        32'hFFFF8001};
        vt[6]  = '{1, 2'b00, 0, 32'h0000_0201, 32'h123456AB,  32'h0,        32'h0,        0, 0, 4'h2, 32'h3456AB00, 4'h0, 32'h0,        32'h0};
        vt[7]  = '{1, 2'b01, 0, 32'h0000_0206, 32'hFFFFBEEF,  32'h0,        32'h0,        0, 0, 4'hC, 32'hBEEF0000, 4'h0, 32'h0,        32'h0};
        vt[8]  = '{0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0,         32'h77660000, 32'h00008899, 0, 0, 4'hC, 32'h0,        4'h3, 32'h0,        32'h88997766};
        vt[9]  = '{0, 2'b00, 1, 32'h0000_0301, 32'h0,         32'h0000C300, 32'h0,        0, 0, 4'h2, 32'h0,        4'h0, 32'h0,        32'hFFFFFFC3};
        vt[10] = '{0, 2'b11, 0, 32'h0000_0400, 32'h0,         32'h01020304, 32'h0,        0, 0, 4'hF, 32'h0,        4'h0, 32'h0,        32'h01020304};
        vt[11] = '{0, 2'b01, 1, 32'h0000_0501, 32'h0,         32'h008F7E00, 32'h0,        0, 0, 4'h6, 32'h0,        4'h0, 32'h0,        32'hFFFF8F7E};
        vt[12] = '{0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hCAFEF00D, 32'h0,        3, 2, 4'hF, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D};
        vt[13] = '{1, 2'b01, 0, 32'h0000_010F, 32'h0000A1B2,  32'h0,        32'h0,        1, 1, 4'h8, 32'hB2000000, 4'h1, 32'h000000A1, 32'h0};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req", data_req, 0);
        check("rst_rvalid", lsu_rvalid, 0);
        check("rst_err", lsu_err, 0);
        check("rst_be", data_be, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_rdata", lsu_rdata, 0);
        check("rst_ready", lsu_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) run_vec(vt[i]);

        // Reset while waiting for the response: request aborted, late rvalid ignored.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'b10; lsu_addr = 32'h100;
        @(negedge clk);
        lsu_req = 1'b0;
        check("abort_req_up", data_req, 1);
        data_gnt = 1'b1;
        @(negedge clk);
        data_gnt = 1'b0;
        check("abort_in_wait", lsu_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_req", data_req, 0);
        check("abort_idle", lsu_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        data_rvalid = 1'b1; data_rdata = 32'h5555AAAA;
        @(negedge clk);
        data_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_rvalid", lsu_rvalid, 0);
            check("abort_no_req", data_req, 0);
            @(negedge clk);
        end

        // Misaligned access with splitting disabled: error pulse, no bus traffic.
        m_req = 1'b1; m_we = 1'b0; m_type = 2'b10; m_addr = 32'h101;
        @(negedge clk);
        m_req = 1'b0;
        check("nomis_err", m_err, 1);
        check("nomis_noreq", m_dreq, 0);
        check("nomis_ready", m_ready, 1);
        @(negedge clk);
        check("nomis_err_pulse", m_err, 0);
        check("nomis_noreq2", m_dreq, 0);
        // A misaligned half inside one word is still legal.
        m_req = 1'b1; m_type = 2'b01; m_sext = 1'b0; m_addr = 32'h101;
        @(negedge clk);
        m_req = 1'b0;
        check("nomis_half_err", m_err, 0);
        check("nomis_half_req", m_dreq, 1);
        check("nomis_half_be", m_dbe, 4'h6);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        m_drvalid = 1'b1; m_drdata = 32'h00BEEF00;
        @(negedge clk);
        m_drvalid = 1'b0;
        check("nomis_half_rvalid", m_rvalid, 1);
        check("nomis_half_rdata", m_rdata, 32'h0000BEEF);

        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
